lcd_receiver: RTL

- Synthesizable HD44780-compatible receiver: the panel side of the 8-bit LCD bus (en, rs, rw, D).
- Decodes commands, maintains the 32-character DDRAM and display-control state, and exposes the screen contents as a packed 256-bit image.
- Used on-chip to mirror LCD traffic to other displays/logic, and as a loopback checker for the LCD driver.

---
 rtl/lcd_receiver_if.sv | 11 +
 rtl/lcd_receiver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_receiver_if.sv
// Panel-side HD44780 8-bit bus: enable strobe, register select, read/write and data.
// The driver owns the master modport; the receiver listens through the slave modport.
interface lcd_receiver_if;
  logic       en;
  logic       rs;
  logic       rw;
  logic [7:0] D;

  modport master (output en, output rs, output rw, output D);
  modport slave  (input  en, input  rs, input  rw, input  D);
endinterface

// File: rtl/lcd_receiver.sv
// HD44780-compatible receiver: synchronizes the LCD bus, decodes commands and data writes,
// and mirrors the 32-byte DDRAM as a packed screen image.
module lcd_receiver #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
  input  logic           clock,
  input  logic           reset_n,
  lcd_receiver_if.slave  bus,
  output logic [255:0]   message_out,
  output logic [6:0]     ac,
  output logic           display_on,
  output logic           cursor_on,
  output logic           blink_on,
  output logic           increment,
  output logic           initialized,
  output logic           busy,
  output logic           overrun,
  output logic           write_strobe
);

  localparam int LAST = SYNC_STAGES - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] en_sync_q;
  logic [SYNC_STAGES-1:0] rs_sync_q;
  logic [SYNC_STAGES-1:0] rw_sync_q;
  logic [7:0]             d_sync_q [SYNC_STAGES];
  logic                   en_prev_q;

  state_t      state_q;
  logic        cmd_rs_q;
  logic [7:0]  cmd_d_q;
  logic [7:0]  ddram_q [32];
  logic [6:0]  ac_q;
  logic [4:0]  clr_cnt_q;
  logic        display_on_q;
  logic        cursor_on_q;
  logic        blink_on_q;
  logic        increment_q;
  logic        initialized_q;
  logic        busy_q;
  logic        overrun_q;
  logic        write_strobe_q;

  logic        strobe_s;
  logic [6:0]  ac_step_d;

  // Two-line address map: line 1 ends at 0x27, line 2 spans 0x40..0x67.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h40)      r = 7'h27;
      else if (a == 7'h00) r = 7'h67;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  function automatic logic ddram_hit(input logic [6:0] a);
    return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
  endfunction

  function automatic logic [4:0] ddram_index(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

  // Bus synchronizer chain plus the delayed enable used for falling-edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en_sync_q <= '0;
      rs_sync_q <= '0;
      rw_sync_q <= '0;
      en_prev_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) d_sync_q[i] <= 8'h00;
    end else begin
      en_sync_q[0] <= bus.en;
      rs_sync_q[0] <= bus.rs;
      rw_sync_q[0] <= bus.rw;
      d_sync_q[0]  <= bus.D;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        en_sync_q[i] <= en_sync_q[i-1];
        rs_sync_q[i] <= rs_sync_q[i-1];
        rw_sync_q[i] <= rw_sync_q[i-1];
        d_sync_q[i]  <= d_sync_q[i-1];
      end
      en_prev_q <= en_sync_q[LAST];
    end
  end

  // Read strobes are not strobes at all as far as state and overrun are concerned.
  always_comb begin
    strobe_s  = en_prev_q & ~en_sync_q[LAST] & ~rw_sync_q[LAST];
    ac_step_d = ac_step(ac_q, increment_q);
  end

  // Control FSM: latch, execute, and the 32-cycle clear sweep.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cmd_rs_q       <= 1'b0;
      cmd_d_q        <= 8'h00;
      ac_q           <= 7'h00;
      clr_cnt_q      <= 5'd0;
      display_on_q   <= 1'b0;
      cursor_on_q    <= 1'b0;
      blink_on_q     <= 1'b0;
      increment_q    <= 1'b1;
      initialized_q  <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      write_strobe_q <= 1'b0;
      for (int k = 0; k < 32; k++) ddram_q[k] <= CLEAR_CHAR;
    end else begin
      write_strobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (strobe_s) begin
            cmd_rs_q <= rs_sync_q[LAST];
            cmd_d_q  <= d_sync_q[LAST];
            state_q  <= EXEC;
          end else begin
            state_q  <= IDLE;
          end
        end
        EXEC: begin
          state_q <= IDLE;
          if (strobe_s) overrun_q <= 1'b1;
          else          overrun_q <= overrun_q;
          if (cmd_rs_q) begin
            if (ddram_hit(ac_q)) begin
              ddram_q[ddram_index(ac_q)] <= cmd_d_q;
              write_strobe_q             <= 1'b1;
            end else begin
              write_strobe_q             <= 1'b0;
            end
            ac_q <= ac_step_d;
          end else begin
            casez (cmd_d_q)
              8'b1???????: ac_q <= cmd_d_q[6:0];
              8'b01??????: ac_q <= ac_q;
              8'b001?????: initialized_q <= 1'b1;
              8'b0001????: begin
                if (!cmd_d_q[3]) ac_q <= ac_step(ac_q, cmd_d_q[2]);
                else             ac_q <= ac_q;
              end
              8'b00001???: begin
                display_on_q <= cmd_d_q[2];
                cursor_on_q  <= cmd_d_q[1];
                blink_on_q   <= cmd_d_q[0];
              end
              8'b000001??: increment_q <= cmd_d_q[1];
              8'b0000001?: ac_q <= 7'h00;
              8'b00000001: begin
                state_q   <= CLEAR;
                busy_q    <= 1'b1;
                clr_cnt_q <= 5'd0;
              end
              default: ac_q <= ac_q;
            endcase
          end
        end
        CLEAR: begin
          ddram_q[clr_cnt_q] <= CLEAR_CHAR;
          if (strobe_s) overrun_q <= 1'b1;
          else          overrun_q <= overrun_q;
          if (clr_cnt_q == 5'd31) begin
            ac_q        <= 7'h00;
            increment_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            clr_cnt_q   <= clr_cnt_q + 5'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Screen image is a plain concatenation of the DDRAM bytes, line 1 in the low half.
  always_comb begin
    message_out = '0;
    for (int k = 0; k < 32; k++) message_out[8*k +: 8] = ddram_q[k];
  end

  assign ac           = ac_q;
  assign display_on   = display_on_q;
  assign cursor_on    = cursor_on_q;
  assign blink_on     = blink_on_q;
  assign increment    = increment_q;
  assign initialized  = initialized_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign write_strobe = write_strobe_q;

endmodule
